// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 keyboard event decoder: prefix FSM, Shift/Caps tracking, repeat
// filtering and a first-word-fall-through event FIFO with a valid/ready pop.

module scanToAscii (
  input  logic [7:0] i_scan_code,
  input  logic       i_extended,
  input  logic       i_letter_case,
  input  logic       i_shift,
  output logic [7:0] o_ascii
);
  logic [7:0] w_upper;
  logic [7:0] w_plain;
  logic [7:0] w_shifted;
  logic [7:0] w_ext_code;

  always_comb begin
    w_upper    = '0;
    w_plain    = '0;
    w_shifted  = '0;
    w_ext_code = '0;
    case (i_scan_code)
      8'h1C: w_upper = 8'h41; 8'h32: w_upper = 8'h42; 8'h21: w_upper = 8'h43;
      8'h23: w_upper = 8'h44; 8'h24: w_upper = 8'h45; 8'h2B: w_upper = 8'h46;
      8'h34: w_upper = 8'h47; 8'h33: w_upper = 8'h48; 8'h43: w_upper = 8'h49;
      8'h3B: w_upper = 8'h4A; 8'h42: w_upper = 8'h4B; 8'h4B: w_upper = 8'h4C;
      8'h3A: w_upper = 8'h4D; 8'h31: w_upper = 8'h4E; 8'h44: w_upper = 8'h4F;
      8'h4D: w_upper = 8'h50; 8'h15: w_upper = 8'h51; 8'h2D: w_upper = 8'h52;
      8'h1B: w_upper = 8'h53; 8'h2C: w_upper = 8'h54; 8'h3C: w_upper = 8'h55;
      8'h2A: w_upper = 8'h56; 8'h1D: w_upper = 8'h57; 8'h22: w_upper = 8'h58;
      8'h35: w_upper = 8'h59; 8'h1A: w_upper = 8'h5A;
      default: w_upper = '0;
    endcase
    case (i_scan_code)
      8'h16: begin w_plain = 8'h31; w_shifted = 8'h21; end
      8'h1E: begin w_plain = 8'h32; w_shifted = 8'h40; end
      8'h26: begin w_plain = 8'h33; w_shifted = 8'h23; end
      8'h25: begin w_plain = 8'h34; w_shifted = 8'h24; end
      8'h2E: begin w_plain = 8'h35; w_shifted = 8'h25; end
      8'h36: begin w_plain = 8'h36; w_shifted = 8'h5E; end
      8'h3D: begin w_plain = 8'h37; w_shifted = 8'h26; end
      8'h3E: begin w_plain = 8'h38; w_shifted = 8'h2A; end
      8'h46: begin w_plain = 8'h39; w_shifted = 8'h28; end
      8'h45: begin w_plain = 8'h30; w_shifted = 8'h29; end
      8'h4E: begin w_plain = 8'h2D; w_shifted = 8'h5F; end
      8'h55: begin w_plain = 8'h3D; w_shifted = 8'h2B; end
      8'h41: begin w_plain = 8'h2C; w_shifted = 8'h3C; end
      8'h49: begin w_plain = 8'h2E; w_shifted = 8'h3E; end
      8'h4A: begin w_plain = 8'h2F; w_shifted = 8'h3F; end
      8'h29: begin w_plain = 8'h20; w_shifted = 8'h20; end
      8'h5A: begin w_plain = 8'h0D; w_shifted = 8'h0D; end
      8'h66: begin w_plain = 8'h08; w_shifted = 8'h08; end
      8'h0D: begin w_plain = 8'h09; w_shifted = 8'h09; end
      8'h76: begin w_plain = 8'h1B; w_shifted = 8'h1B; end
      default: begin w_plain = '0; w_shifted = '0; end
    endcase
    // Extended keys: arrows map to DC1..DC4 control codes, Delete to DEL
    case (i_scan_code)
      8'h75: w_ext_code = 8'h11;
      8'h72: w_ext_code = 8'h12;
      8'h6B: w_ext_code = 8'h13;
      8'h74: w_ext_code = 8'h14;
      8'h5A: w_ext_code = 8'h0D;
      8'h4A: w_ext_code = 8'h2F;
      8'h71: w_ext_code = 8'h7F;
      default: w_ext_code = '0;
    endcase
    if (i_extended)
      o_ascii = w_ext_code;
    else if (w_upper != '0)
      o_ascii = i_letter_case ? w_upper : (w_upper | 8'h20);
    else
      o_ascii = i_shift ? w_shifted : w_plain;
  end
endmodule

module ps2_key_event_fifo #(
  parameter int FIFO_DEPTH   = 8,
  parameter int REPORT_BREAK = 0,
  parameter int AUTO_REPEAT  = 1
) (
  input  logic                         sysclk,
  input  logic                         reset,
  input  logic                         scan_valid,
  input  logic [7:0]                   scan_code,
  input  logic                         key_ready,
  output logic                         key_valid,
  output logic [7:0]                   key_ascii,
  output logic                         key_release,
  output logic                         key_extended,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  output logic                         shift_active,
  output logic                         caps_lock
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t        r_state, w_state_n;
  logic          w_evt, w_rel, w_ext, w_ignore;
  logic          r_shift, r_caps, r_caps_held, r_overflow;
  logic [8:0]    r_last_make;
  logic [8:0]    w_key;
  logic          w_is_shift, w_is_caps, w_repeat, w_queue;
  logic [7:0]    w_ascii;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [9:0]    w_head;
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  logic          w_nonempty, w_full, w_pop, w_wr;

  assign w_ignore = scan_code inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF};

  always_comb begin
    w_state_n = r_state;
    w_evt     = 1'b0;
    w_rel     = 1'b0;
    w_ext     = 1'b0;
    if (scan_valid) begin
      case (r_state)
        S_IDLE: begin
          if (scan_code == 8'hE0)      w_state_n = S_EXT;
          else if (scan_code == 8'hF0) w_state_n = S_BRK;
          else if (!w_ignore)          w_evt     = 1'b1;
        end
        S_EXT: begin
          if (scan_code == 8'hF0) w_state_n = S_EXT_BRK;
          else if (scan_code != 8'hE0) begin
            w_evt     = 1'b1;
            w_ext     = 1'b1;
            w_state_n = S_IDLE;
          end
        end
        S_BRK: begin
          w_evt     = 1'b1;
          w_rel     = 1'b1;
          w_state_n = S_IDLE;
        end
        S_EXT_BRK: begin
          w_evt     = 1'b1;
          w_rel     = 1'b1;
          w_ext     = 1'b1;
          w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  scanToAscii u_scan_to_ascii (
    .i_scan_code   (scan_code),
    .i_extended    (w_ext),
    .i_letter_case (r_shift ^ r_caps),
    .i_shift       (r_shift),
    .o_ascii       (w_ascii)
  );

  assign w_key      = {w_ext, scan_code};
  assign w_is_shift = !w_ext && (scan_code == 8'h12 || scan_code == 8'h59);
  assign w_is_caps  = (scan_code == 8'h58);
  assign w_repeat   = (r_last_make == w_key);
  assign w_queue    = w_evt && !w_is_shift && !w_is_caps && (w_ascii != '0) &&
                      (w_rel ? (REPORT_BREAK != 0) : ((AUTO_REPEAT != 0) || !w_repeat));

  // Count never exceeds FIFO_DEPTH (a power of two), so its MSB alone means full
  assign w_nonempty = (r_count != '0);
  assign w_full     = r_count[AW];
  assign w_pop      = w_nonempty && key_ready;
  assign w_wr       = w_queue && (!w_full || w_pop);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_shift     <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_last_make <= '0;
      r_overflow  <= 1'b0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_evt && w_is_shift) r_shift <= !w_rel;
      if (w_evt && w_is_caps) begin
        if (w_rel) r_caps_held <= 1'b0;
        else if (!r_caps_held) begin
          r_caps      <= !r_caps;
          r_caps_held <= 1'b1;
        end
      end
      if (w_evt && !w_rel)              r_last_make <= w_key;
      else if (w_evt && w_rel && w_repeat) r_last_make <= '0;
      if (w_queue && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_wr)  r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_wr) r_mem[r_wr] <= {w_ascii, w_rel, w_ext};
  end

  assign w_head       = r_mem[r_rd];
  assign key_valid    = w_nonempty;
  assign key_ascii    = w_nonempty ? w_head[9:2] : '0;
  assign key_release  = w_nonempty ? w_head[1] : 1'b0;
  assign key_extended = w_nonempty ? w_head[0] : 1'b0;
  assign fifo_count   = r_count;
  assign overflow     = r_overflow;
  assign shift_active = r_shift;
  assign caps_lock    = r_caps;
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Self-checking bench: three configurations share one byte stream; each is
// compared every cycle with a queue-based event model.

module tb_ps2_key_event_fifo;
  logic       clk = 1'b0;
  logic       rst;
  logic       sv;
  logic [7:0] code;
  logic       rdy;

  logic [2:0] v, rl, ex, ov, sh, cp;
  logic [7:0] as0, as1, as2;
  logic [3:0] c0, c2;
  logic [2:0] c1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_key_event_fifo #(.FIFO_DEPTH(8), .REPORT_BREAK(0), .AUTO_REPEAT(1)) dut0 (
    .sysclk(clk), .reset(rst), .scan_valid(sv), .scan_code(code), .key_ready(rdy),
    .key_valid(v[0]), .key_ascii(as0), .key_release(rl[0]), .key_extended(ex[0]),
    .fifo_count(c0), .overflow(ov[0]), .shift_active(sh[0]), .caps_lock(cp[0]));
  ps2_key_event_fifo #(.FIFO_DEPTH(4), .REPORT_BREAK(1), .AUTO_REPEAT(1)) dut1 (
    .sysclk(clk), .reset(rst), .scan_valid(sv), .scan_code(code), .key_ready(rdy),
    .key_valid(v[1]), .key_ascii(as1), .key_release(rl[1]), .key_extended(ex[1]),
    .fifo_count(c1), .overflow(ov[1]), .shift_active(sh[1]), .caps_lock(cp[1]));
  ps2_key_event_fifo #(.FIFO_DEPTH(8), .REPORT_BREAK(0), .AUTO_REPEAT(0)) dut2 (
    .sysclk(clk), .reset(rst), .scan_valid(sv), .scan_code(code), .key_ready(rdy),
    .key_valid(v[2]), .key_ascii(as2), .key_release(rl[2]), .key_extended(ex[2]),
    .fifo_count(c2), .overflow(ov[2]), .shift_active(sh[2]), .caps_lock(cp[2]));

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] a; logic r; logic e; } ent_t;
  ent_t q0[$], q1[$], q2[$];
  int depth [3] = '{8, 4, 8};
  int rb    [3] = '{0, 1, 0};
  int ar    [3] = '{1, 1, 0};
  bit pe[3], pb[3], msh[3], mcp[3], mhd[3], movf[3];
  int mlast[3];

  logic [7:0] up_tab [256];
  logic [7:0] lo_tab [256];
  logic [7:0] hi_tab [256];
  logic [7:0] ex_tab [256];

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] sym_codes [16] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
    8'h46, 8'h45, 8'h4E, 8'h55, 8'h41, 8'h49, 8'h4A, 8'h29};
  logic [7:0] misc_codes [12] = '{8'h5A, 8'h66, 8'h0D, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74,
    8'h71, 8'h12, 8'h59, 8'h58};

  function automatic void init_tables();
    string letters = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
    string sym_lo  = "1234567890-=,./ ";
    string sym_hi  = "!@#$%^&*()_+<>? ";
    for (int i = 0; i < 256; i++) begin
      up_tab[i] = 8'h00; lo_tab[i] = 8'h00; hi_tab[i] = 8'h00; ex_tab[i] = 8'h00;
    end
    for (int i = 0; i < 26; i++) up_tab[letter_codes[i]] = letters[i];
    for (int i = 0; i < 16; i++) begin
      lo_tab[sym_codes[i]] = sym_lo[i];
      hi_tab[sym_codes[i]] = sym_hi[i];
    end
    lo_tab[8'h5A] = 8'h0D; hi_tab[8'h5A] = 8'h0D;
    lo_tab[8'h66] = 8'h08; hi_tab[8'h66] = 8'h08;
    lo_tab[8'h0D] = 8'h09; hi_tab[8'h0D] = 8'h09;
    lo_tab[8'h76] = 8'h1B; hi_tab[8'h76] = 8'h1B;
    ex_tab[8'h75] = 8'h11; ex_tab[8'h72] = 8'h12; ex_tab[8'h6B] = 8'h13;
    ex_tab[8'h74] = 8'h14; ex_tab[8'h5A] = 8'h0D; ex_tab[8'h4A] = 8'h2F;
    ex_tab[8'h71] = 8'h7F;
  endfunction

  function automatic logic [7:0] ref_ascii(logic [7:0] c, bit e, bit s, bit k);
    if (e) return ex_tab[c];
    if (up_tab[c] != 8'h00) return (s ^ k) ? up_tab[c] : up_tab[c] + 8'd32;
    return s ? hi_tab[c] : lo_tab[c];
  endfunction

  function automatic int qsize(int k);
    if (k == 0) return q0.size();
    if (k == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic ent_t qhead(int k);
    if (k == 0) return q0[0];
    if (k == 1) return q1[0];
    return q2[0];
  endfunction

  function automatic void qpop(int k);
    if (k == 0) void'(q0.pop_front());
    else if (k == 1) void'(q1.pop_front());
    else void'(q2.pop_front());
  endfunction

  function automatic void qpush(int k, ent_t e);
    if (k == 0) q0.push_back(e);
    else if (k == 1) q1.push_back(e);
    else q2.push_back(e);
  endfunction

  function automatic void model_reset(int k);
    pe[k] = 0; pb[k] = 0; msh[k] = 0; mcp[k] = 0; mhd[k] = 0; movf[k] = 0; mlast[k] = -1;
    if (k == 0) q0.delete(); else if (k == 1) q1.delete(); else q2.delete();
  endfunction

  function automatic void model_step(int k, bit s_v, logic [7:0] c, bit r);
    bit evt = 0, rel = 0, ext = 0, push, pop, is_shift, is_caps;
    int key, n;
    ent_t e;
    if (s_v) begin
      if (pb[k]) begin
        evt = 1; rel = 1; ext = pe[k]; pb[k] = 0; pe[k] = 0;
      end else if (pe[k]) begin
        if (c == 8'hF0) pb[k] = 1;
        else if (c != 8'hE0) begin evt = 1; ext = 1; pe[k] = 0; end
      end else begin
        if (c == 8'hE0) pe[k] = 1;
        else if (c == 8'hF0) pb[k] = 1;
        else if (!(c inside {8'hE1, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF})) evt = 1;
      end
    end
    key      = int'(ext) * 256 + int'(c);
    is_shift = !ext && (c == 8'h12 || c == 8'h59);
    is_caps  = (c == 8'h58);
    e.a = ref_ascii(c, ext, msh[k], mcp[k]);
    e.r = rel;
    e.e = ext;
    push = evt && !is_shift && !is_caps && (e.a != 8'h00) &&
           (rel ? (rb[k] != 0) : (ar[k] != 0 || mlast[k] != key));
    n   = qsize(k);
    pop = (n > 0) && r;
    if (pop) qpop(k);
    if (push) begin
      if (n < depth[k] || pop) qpush(k, e);
      else movf[k] = 1;
    end
    if (evt && is_shift) msh[k] = !rel;
    if (evt && is_caps) begin
      if (rel) mhd[k] = 0;
      else if (!mhd[k]) begin mcp[k] = !mcp[k]; mhd[k] = 1; end
    end
    if (evt) begin
      if (!rel) mlast[k] = key;
      else if (mlast[k] == key) mlast[k] = -1;
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic check_dut(input int k);
    logic [3:0] oc;
    logic [7:0] oa;
    ent_t h;
    case (k)
      0:       begin oc = c0;          oa = as0; end
      1:       begin oc = {1'b0, c1};  oa = as1; end
      default: begin oc = c2;          oa = as2; end
    endcase
    chk($sformatf("d%0d.valid", k), 32'(v[k]), 32'(qsize(k) > 0));
    chk($sformatf("d%0d.count", k), 32'(oc), 32'(qsize(k)));
    chk($sformatf("d%0d.overflow", k), 32'(ov[k]), 32'(movf[k]));
    chk($sformatf("d%0d.shift", k), 32'(sh[k]), 32'(msh[k]));
    chk($sformatf("d%0d.caps", k), 32'(cp[k]), 32'(mcp[k]));
    if (qsize(k) > 0) begin
      h = qhead(k);
      chk($sformatf("d%0d.ascii", k), 32'(oa), 32'(h.a));
      chk($sformatf("d%0d.release", k), 32'(rl[k]), 32'(h.r));
      chk($sformatf("d%0d.extended", k), 32'(ex[k]), 32'(h.e));
    end
  endtask

  task automatic step(input bit s_v, input logic [7:0] c, input bit r);
    sv = s_v; code = c; rdy = r;
    for (int k = 0; k < 3; k++) model_step(k, s_v, c, r);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check_dut(k);
  endtask

  task automatic do_reset();
    sv = 0; rdy = 0; code = 8'h00;
    rst = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      model_reset(k);
      chk($sformatf("d%0d.rst_valid", k), 32'(v[k]), 32'd0);
      chk($sformatf("d%0d.rst_ovf", k), 32'(ov[k]), 32'd0);
      chk($sformatf("d%0d.rst_shift", k), 32'(sh[k]), 32'd0);
      chk($sformatf("d%0d.rst_caps", k), 32'(cp[k]), 32'd0);
    end
    chk("rst_ascii", 32'({as0, as1, as2}), 32'd0);
    chk("rst_count", 32'({c0, c1, c2}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic keys(input logic [7:0] seq [$], input bit r);
    foreach (seq[i]) step(1'b1, seq[i], r);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  function automatic logic [7:0] rnd_code(logic [7:0] prev);
    int sel = $urandom_range(0, 99);
    if (sel < 15) return prev;
    if (sel < 45) return letter_codes[$urandom_range(0, 25)];
    if (sel < 55) return sym_codes[$urandom_range(0, 15)];
    if (sel < 67) return misc_codes[$urandom_range(0, 11)];
    if (sel < 75) return 8'hE0;
    if (sel < 90) return 8'hF0;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [7:0] prev;
    int rp;
    init_tables();
    sv = 0; code = 8'h00; rdy = 0; rst = 1'b0;
    do_reset();

    // 1: single make, valid one cycle after the strobe
    step(1'b1, 8'h1C, 1'b0);
    chk("t1.valid_after_make", 32'(v[0]), 32'd1);
    chk("t1.ascii", 32'(as0), 32'h61);
    keys('{8'hF0, 8'h1C}, 1'b0);
    chk("t1.count", 32'(c0), 32'd1);
    drain();

    // 2: shift and caps
    do_reset();
    keys('{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h58, 8'hF0, 8'h58, 8'h1C}, 1'b0);
    chk("t2.count", 32'(c0), 32'd2);
    chk("t2.ascii", 32'(as0), 32'h41);
    chk("t2.caps", 32'(cp[0]), 32'd1);
    chk("t2.shift", 32'(sh[0]), 32'd0);
    drain();

    // 3: extended make and break with break reporting
    do_reset();
    keys('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}, 1'b0);
    chk("t3.count", 32'(c1), 32'd2);
    chk("t3.ext", 32'(ex[1]), 32'd1);
    chk("t3.rel_first", 32'(rl[1]), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("t3.rel_second", 32'(rl[1]), 32'd1);
    drain();

    // 4: typematic repeats dropped when auto-repeat is off
    do_reset();
    keys('{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}, 1'b0);
    chk("t4.count_norepeat", 32'(c2), 32'd1);
    chk("t4.count_repeat", 32'(c0), 32'd4);
    drain();

    // 5: overflow, then push+pop while full
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, letter_codes[i], 1'b0);
    chk("t5.count_full", 32'(c0), 32'd8);
    chk("t5.overflow", 32'(ov[0]), 32'd1);
    step(1'b1, letter_codes[9], 1'b1);
    chk("t5.count_pushpop", 32'(c0), 32'd8);
    chk("t5.head_after_pop", 32'(as0), 32'h62);
    drain();

    // 6: reset in the middle of an E0 F0 sequence
    do_reset();
    keys('{8'h1C, 8'hE0}, 1'b0);
    do_reset();
    chk("t6.empty", 32'(c0), 32'd0);
    step(1'b1, 8'h1C, 1'b0);
    chk("t6.ascii", 32'(as0), 32'h61);
    chk("t6.ext", 32'(ex[0]), 32'd0);
    drain();

    // randomized traffic with changing consumer back-pressure
    prev = 8'h1C;
    rp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rp = (i / 200 % 3 == 0) ? 10 : ((i / 200 % 3 == 1) ? 50 : 90);
      if ($urandom_range(0, 399) == 0) do_reset();
      else begin
        logic [7:0] c;
        c = rnd_code(prev);
        prev = c;
        step($urandom_range(0, 99) < 60, c, $urandom_range(0, 99) < rp);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
